ofmap_streamer: RTL and testbench

Drains the output feature map produced by cnn_accelerator once its done flag fires. It reads the ofmap storage through a 1-cycle-latency row/column read port and emits pixels in raster order on a valid/ready stream, with frame and line markers. It sits between the accelerator's out_feature storage and the downstream host/DMA link. It is the read-out counterpart to the bench-side loader that fills ifmap.

---
 rtl/ofmap_streamer.sv | 168 ++++++++++++++++
 tb/tb_ofmap_streamer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_streamer.sv
// Streams the cnn_accelerator output feature map in raster order on a valid/ready link.
// Optional OFMAP_STREAM_CHECKSUM_EN adds a 16-bit running sum of accepted pixels.
module ofmap_streamer #(
  parameter int unsigned OFMAP_HEIGHT = 128,
  parameter int unsigned OFMAP_WIDTH  = 128,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ROW_W        = (OFMAP_HEIGHT > 1) ? $clog2(OFMAP_HEIGHT) : 1,
  parameter int unsigned COL_W        = (OFMAP_WIDTH > 1) ? $clog2(OFMAP_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  rd_en,
  output logic [ROW_W-1:0]      rd_row,
  output logic [COL_W-1:0]      rd_col,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_last,
  output logic                  busy,
  output logic                  frame_done
`ifdef OFMAP_STREAM_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam logic [ROW_W-1:0] RowMax = ROW_W'(OFMAP_HEIGHT - 1);
  localparam logic [COL_W-1:0] ColMax = COL_W'(OFMAP_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  typedef struct packed {
    logic                  last;
    logic                  eol;
    logic                  sof;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  state_e           state_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             inflight_q;
  logic             inf_sof_q;
  logic             inf_eol_q;
  logic             inf_last_q;
  beat_t            fifo_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             frame_done_q;
`ifdef OFMAP_STREAM_CHECKSUM_EN
  logic [15:0]      checksum_q;
`endif

  beat_t      head;
  logic       push;
  logic       pop;
  logic       col_last;
  logic       row_last;
  logic [2:0] credit_sum;

  always_comb begin
    head       = fifo_q[rd_ptr_q];
    push       = inflight_q;
    pop        = (count_q != 2'd0) & m_ready;
    col_last   = (col_q == ColMax);
    row_last   = (row_q == RowMax);
    // The read issued now lands in the FIFO two edges later, after at most one more pop.
    credit_sum = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en      = (state_q == StIssue) && (credit_sum < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      inflight_q   <= 1'b0;
      inf_sof_q    <= 1'b0;
      inf_eol_q    <= 1'b0;
      inf_last_q   <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      frame_done_q <= 1'b0;
`ifdef OFMAP_STREAM_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      inflight_q   <= rd_en;
      inf_sof_q    <= (row_q == '0) && (col_q == '0);
      inf_eol_q    <= col_last;
      inf_last_q   <= col_last && row_last;

`ifdef OFMAP_STREAM_CHECKSUM_EN
      if (pop) begin
        checksum_q <= checksum_q + 16'(head.data);
      end
`endif

      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StIssue;
            row_q   <= '0;
            col_q   <= '0;
`ifdef OFMAP_STREAM_CHECKSUM_EN
            checksum_q <= '0;
`endif
          end
        end
        StIssue: begin
          if (rd_en) begin
            if (col_last) begin
              col_q <= '0;
              if (row_last) begin
                row_q   <= '0;
                state_q <= StDrain;
              end else begin
                row_q <= row_q + ROW_W'(1);
              end
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
        end
        StDrain: begin
          if (pop && head.last) begin
            state_q      <= StIdle;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Flags ride alongside the pixel so backpressure cannot separate them.
      if (push) begin
        fifo_q[wr_ptr_q] <= {inf_last_q, inf_eol_q, inf_sof_q, rd_data};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rd_row     = row_q;
  assign rd_col     = col_q;
  assign m_valid    = (count_q != 2'd0);
  assign m_data     = head.data;
  assign m_sof      = m_valid & head.sof;
  assign m_eol      = m_valid & head.eol;
  assign m_last     = m_valid & head.last;
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
`ifdef OFMAP_STREAM_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_ofmap_streamer.sv
// Bench for ofmap_streamer: a 4x3 instance driven by a per-cycle table and a scoreboard,
// plus a 1x1 instance exercising back-to-back frames with start held high.
module tb_ofmap_streamer;

  localparam int H = 4;
  localparam int W = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       m_ready;
  logic       rd_en;
  logic [1:0] rd_row;
  logic [1:0] rd_col;
  logic [7:0] rd_data;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_sof;
  logic       m_eol;
  logic       m_last;
  logic       busy;
  logic       frame_done;

  logic       b_start;
  logic       b_ready;
  logic       b_rd_en;
  logic [0:0] b_rd_row;
  logic [0:0] b_rd_col;
  logic [7:0] b_rd_data;
  logic       b_m_valid;
  logic [7:0] b_m_data;
  logic       b_m_sof;
  logic       b_m_eol;
  logic       b_m_last;
  logic       b_busy;
  logic       b_frame_done;

`ifdef OFMAP_STREAM_CHECKSUM_EN
  logic [15:0] checksum;
  logic [15:0] b_checksum;
  int          exp_sum;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       last;
  } beat_t;

  typedef struct {
    logic        ready;
    logic [14:0] exp;
  } vec_t;

  beat_t sb [$];
  vec_t  tab [17];
  logic  mon_en = 1'b0;
  int    exp_idx;
  int    issued;
  int    accepted;
  int    max_out;
  logic  prev_stall;
  logic [11:0] prev_head;

  always #5 clk = ~clk;

  ofmap_streamer #(.OFMAP_HEIGHT(H), .OFMAP_WIDTH(W), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rd_en      (rd_en),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .m_last     (m_last),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef OFMAP_STREAM_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  ofmap_streamer #(.OFMAP_HEIGHT(1), .OFMAP_WIDTH(1), .DATA_WIDTH(8)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (b_start),
    .rd_en      (b_rd_en),
    .rd_row     (b_rd_row),
    .rd_col     (b_rd_col),
    .rd_data    (b_rd_data),
    .m_valid    (b_m_valid),
    .m_ready    (b_ready),
    .m_data     (b_m_data),
    .m_sof      (b_m_sof),
    .m_eol      (b_m_eol),
    .m_last     (b_m_last),
    .busy       (b_busy),
    .frame_done (b_frame_done)
`ifdef OFMAP_STREAM_CHECKSUM_EN
    ,
    .checksum   (b_checksum)
`endif
  );

  // Storage models: 1-cycle read latency, value = row*16 + col.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= {2'b00, rd_row, 4'b0000} | {6'b000000, rd_col};
    if (b_rd_en) b_rd_data <= {3'b000, b_rd_row, 4'b0000} | {7'b0000000, b_rd_col};
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [14:0] exp_a(input int c);
    int b;
    logic mv;
    b  = c - 3;
    mv = (c >= 3) && (c <= 14);
    return {(c >= 1) && (c <= 14), (c >= 1) && (c <= 12), mv, mv && (b == 0),
            mv && (b % W == W - 1), mv && (b == H * W - 1), c == 15,
            mv ? 8'((b / W) * 16 + b % W) : 8'h00};
  endfunction

  function automatic logic [14:0] exp_b(input int c);
    int p;
    p = (c - 1) % 4;
    return {p != 3, p == 0, p == 2, p == 2, p == 2, p == 2, p == 3, 8'h00};
  endfunction

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      1:       return (c % 4 == 0) || (c % 4 == 3);
      2:       return c >= 11;
      default: return 1'b1;
    endcase
  endfunction

  task automatic begin_frame();
    beat_t e;
    sb.delete();
`ifdef OFMAP_STREAM_CHECKSUM_EN
    exp_sum = 0;
`endif
    for (int i = 0; i < H * W; i++) begin
      e.data = 8'((i / W) * 16 + i % W);
      e.sof  = (i == 0);
      e.eol  = (i % W == W - 1);
      e.last = (i == H * W - 1);
      sb.push_back(e);
`ifdef OFMAP_STREAM_CHECKSUM_EN
      exp_sum += int'(e.data);
`endif
    end
    exp_idx    = 0;
    issued     = 0;
    accepted   = 0;
    max_out    = 0;
    prev_stall = 1'b0;
    mon_en     = 1'b1;
  endtask

  task automatic end_frame(input string tag);
    #1;
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({tag, "_issued"}, 32'(issued), 32'(H * W));
    check({tag, "_accepted"}, 32'(accepted), 32'(H * W));
    checks++;
    if (max_out > 2) begin
      failures++;
      $display("FAIL %s_occupancy got=%0d required<=2", tag, max_out);
    end
  endtask

  task automatic run_frame(input int mode, input string tag);
    int done_c;
    done_c = -1;
    begin_frame();
    @(negedge clk);
    start   = 1'b1;
    m_ready = ready_for(mode, 0);
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      start   = 1'b0;
      m_ready = ready_for(mode, c);
      @(negedge clk);
`ifdef OFMAP_STREAM_CHECKSUM_EN
      if (c == 1) check({tag, "_checksum_clear"}, 32'(checksum), 32'd0);
`endif
      if (mode == 2 && c == 10) check({tag, "_reads_while_stalled"}, 32'(issued), 32'd2);
      if (frame_done) begin
        done_c = c;
        break;
      end
    end
    checks++;
    if (done_c < 0) begin
      failures++;
      $display("FAIL %s_timeout got=no_frame_done required=frame_done", tag);
    end
`ifdef OFMAP_STREAM_CHECKSUM_EN
    check({tag, "_checksum"}, 32'(checksum), 32'(exp_sum));
`endif
    end_frame(tag);
  endtask

  // Scoreboard monitor: addresses, beat order/content, hold under backpressure.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (issued - accepted > max_out) max_out = issued - accepted;
        if (prev_stall) check("hold", 32'({m_valid, m_sof, m_eol, m_last, m_data}),
                              32'(prev_head));
        if (rd_en) begin
          if (exp_idx >= H * W) begin
            checks++;
            failures++;
            $display("FAIL addr_overrun got=%0d,%0d required=none", rd_row, rd_col);
          end else begin
            check("rd_addr", 32'({rd_row, rd_col}), 32'({2'(exp_idx / W), 2'(exp_idx % W)}));
          end
          exp_idx++;
          issued++;
        end
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_beat got=%0h required=none", m_data);
          end else begin
            e = sb.pop_front();
            check("beat", 32'({m_data, m_sof, m_eol, m_last}), 32'(e));
          end
          accepted++;
        end
        prev_stall = m_valid && !m_ready;
        prev_head  = {m_valid, m_sof, m_eol, m_last, m_data};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    m_ready = 1'b0;
    b_start = 1'b0;
    b_ready = 1'b0;
    for (int c = 0; c < 17; c++) begin
      tab[c].ready = 1'b1;
      tab[c].exp   = exp_a(c);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_a", 32'({rd_en, rd_row, rd_col, m_valid, m_data, m_sof, m_eol, m_last, busy,
                          frame_done}), 32'd0);
    check("reset_b", 32'({b_rd_en, b_m_valid, b_m_data, b_m_sof, b_m_eol, b_m_last, b_busy,
                          b_frame_done}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Per-cycle table, m_ready held high.
    begin_frame();
    @(negedge clk);
    start   = 1'b1;
    m_ready = tab[0].ready;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 17; c++) begin
      m_ready = tab[c].ready;
      @(negedge clk);
      check($sformatf("table_cycle%0d", c),
            32'({busy, rd_en, m_valid, m_sof, m_eol, m_last, frame_done,
                 (m_valid ? m_data : 8'h00)}), 32'(tab[c].exp));
`ifdef OFMAP_STREAM_CHECKSUM_EN
      if (c == 15) check("table_checksum", 32'(checksum), 32'(exp_sum));
`endif
      @(posedge clk);
      #1;
    end
    end_frame("table");

    run_frame(1, "toggle");
    run_frame(2, "stalled");

    // Reset while beat 5 is held at the head.
    mon_en = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    m_ready = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    check("pending_beat5", 32'({m_valid, m_data, m_sof, m_eol, m_last}),
          32'({1'b1, 8'd18, 1'b0, 1'b1, 1'b0}));
    @(posedge clk);
    #1;
    reset   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("after_reset", 32'({rd_en, rd_row, rd_col, m_valid, m_data, m_sof, m_eol, m_last,
                              busy, frame_done}), 32'd0);
`ifdef OFMAP_STREAM_CHECKSUM_EN
    check("after_reset_checksum", 32'(checksum), 32'd0);
`endif
    run_frame(0, "post_reset");
    mon_en = 1'b0;

    // 1x1 frames with start held high.
    @(negedge clk);
    b_ready = 1'b1;
    b_start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("b_cycle%0d", c),
            32'({b_busy, b_rd_en, b_m_valid, b_m_sof, b_m_eol, b_m_last, b_frame_done,
                 (b_m_valid ? b_m_data : 8'h00)}), 32'(exp_b(c)));
    end
    b_start = 1'b0;
    repeat (6) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
